// File: rtl/snn_inject_pkg.sv
// Shared types and constants for the spike packet injector.
// Packet field positions exist only for debug decode; the datapath treats packets as opaque.
package snn_inject_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        TICK  = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam int PKT_W    = 30;
    localparam int DX_MSB   = 29;
    localparam int DY_MSB   = 20;
    localparam int AXON_MSB = 11;
    localparam int DT_MSB   = 3;

    typedef struct packed {
        logic [DX_MSB-DY_MSB-1:0]   dx;
        logic [DY_MSB-AXON_MSB-1:0] dy;
        logic [AXON_MSB-DT_MSB-1:0] axon;
        logic [DT_MSB:0]            dt;
    } pkt_fields_t;

    function automatic pkt_fields_t pkt_decode(input logic [PKT_W-1:0] pkt);
        pkt_fields_t f;
        f.dx   = pkt[DX_MSB:DY_MSB+1];
        f.dy   = pkt[DY_MSB:AXON_MSB+1];
        f.axon = pkt[AXON_MSB:DT_MSB+1];
        f.dt   = pkt[DT_MSB:0];
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: the head entry is visible on rdata whenever empty is low.
// Writes while full and reads while empty are ignored; flags and level are registered.
module sync_fifo_fwft #(
    parameter int DEPTH = 256,
    parameter int PKT_W = 30,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wen,
    input  logic [PKT_W-1:0] wdata,
    input  logic             ren,
    output logic [PKT_W-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [PKT_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CNT_W-1:0] level_r;
    logic [CNT_W-1:0] level_s;
    logic             full_r;
    logic             empty_r;
    logic             wr_s;
    logic             rd_s;

    // Qualify requests against the current flags and compute the next occupancy.
    always_comb begin
        wr_s    = wen && !full_r;
        rd_s    = ren && !empty_r;
        level_s = level_r;
        if (wr_s && !rd_s) begin
            level_s = level_r + CNT_W'(1);
        end else if (!wr_s && rd_s) begin
            level_s = level_r - CNT_W'(1);
        end else begin
            level_s = level_r;
        end
    end

    // Storage array; left unreset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers, occupancy and registered flags; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r <= level_s;
            full_r  <= (level_s == CNT_W'(DEPTH));
            empty_r <= (level_s == CNT_W'(0));
        end
    end

    assign rdata = empty_r ? {PKT_W{1'b0}} : mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign level = level_r;

endmodule

// File: rtl/spike_packet_injector.sv
// Frame sequencer in front of an SNN core: drains a snapshot of the host FIFO into the core's
// west input, then issues one tick and waits (bounded) for the core's tick_ready.
module spike_packet_injector #(
    parameter int PKT_W   = snn_inject_pkg::PKT_W,
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             host_wen,
    input  logic [PKT_W-1:0] host_data,
    output logic             host_full,
    output logic [CNT_W-1:0] host_level,
    input  logic             start,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] sent_count,
    output logic [PKT_W-1:0] pkt_out,
    output logic             empty_out,
    input  logic             ren_in,
    output logic             tick_out,
    input  logic             tick_ready_in,
    output logic             overflow_err,
    output logic             underflow_err,
    output logic             timeout_err
);

    import snn_inject_pkg::*;

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] frame_len_r;
    logic [CNT_W-1:0] remaining_r;
    logic [CNT_W-1:0] sent_count_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             overflow_r;
    logic             underflow_r;
    logic             timeout_r;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_level_s;
    logic [PKT_W-1:0] fifo_rdata_s;
    logic             empty_s;
    logic             pop_s;
    logic             tmo_hit_s;
    logic             frame_done_s;

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .PKT_W (PKT_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wen   (host_wen),
        .wdata (host_data),
        .ren   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    // The core only sees data while the current frame still owes entries; remaining never
    // exceeds the FIFO level, so the FIFO's own empty flag is redundant here.
    always_comb begin
        empty_s   = !((state_r == DRAIN) && (remaining_r != CNT_W'(0)));
        pop_s     = ren_in && !empty_s;
        tmo_hit_s = (tmo_cnt_r == TMO_W'(TIMEOUT - 1));
    end

    // Next-state and frame_done decode.
    always_comb begin
        state_s      = state_r;
        frame_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = (fifo_level_s == CNT_W'(0)) ? TICK : DRAIN;
                end else begin
                    state_s = IDLE;
                end
            end
            DRAIN: begin
                if (pop_s && (remaining_r == CNT_W'(1))) begin
                    state_s = TICK;
                end else begin
                    state_s = DRAIN;
                end
            end
            TICK: begin
                if (frame_len_r == CNT_W'(0)) begin
                    state_s      = IDLE;
                    frame_done_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            WAIT: begin
                if (tick_ready_in || tmo_hit_s) begin
                    state_s      = IDLE;
                    frame_done_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame snapshot, pop accounting and tick timeout counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_len_r  <= {CNT_W{1'b0}};
            remaining_r  <= {CNT_W{1'b0}};
            sent_count_r <= {CNT_W{1'b0}};
            tmo_cnt_r    <= {TMO_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        frame_len_r  <= fifo_level_s;
                        remaining_r  <= fifo_level_s;
                        sent_count_r <= {CNT_W{1'b0}};
                    end
                end
                DRAIN: begin
                    if (pop_s) begin
                        sent_count_r <= sent_count_r + CNT_W'(1);
                        remaining_r  <= remaining_r - CNT_W'(1);
                    end
                end
                TICK: begin
                    tmo_cnt_r <= {TMO_W{1'b0}};
                end
                WAIT: begin
                    tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                end
                default: begin
                    tmo_cnt_r <= {TMO_W{1'b0}};
                end
            endcase
        end
    end

    // Sticky fault flags; a tick_ready arriving on the final count wins over the timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            overflow_r  <= overflow_r  || (host_wen && fifo_full_s);
            underflow_r <= underflow_r || (ren_in && empty_s);
            timeout_r   <= timeout_r   || ((state_r == WAIT) && tmo_hit_s && !tick_ready_in);
        end
    end

    assign host_full     = fifo_full_s;
    assign host_level    = fifo_level_s;
    assign busy          = (state_r != IDLE);
    assign frame_done    = frame_done_s;
    assign sent_count    = sent_count_r;
    assign pkt_out       = fifo_rdata_s;
    assign empty_out     = empty_s;
    assign tick_out      = (state_r == TICK);
    assign overflow_err  = overflow_r;
    assign underflow_err = underflow_r;
    assign timeout_err   = timeout_r;

endmodule

// File: tb/tb_spike_packet_injector.sv
// Directed bench for spike_packet_injector: frame drain, empty frame, late host writes,
// overflow, tick timeout, underflow and mid-frame reset.
module tb_spike_packet_injector;

    localparam int PKT_W   = 30;
    localparam int DEPTH   = 256;
    localparam int TIMEOUT = 4096;
    localparam int CNT_W   = 9;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             host_wen = 1'b0;
    logic [PKT_W-1:0] host_data = '0;
    logic             host_full;
    logic [CNT_W-1:0] host_level;
    logic             start = 1'b0;
    logic             busy;
    logic             frame_done;
    logic [CNT_W-1:0] sent_count;
    logic [PKT_W-1:0] pkt_out;
    logic             empty_out;
    logic             ren_in = 1'b0;
    logic             tick_out;
    logic             tick_ready_in = 1'b0;
    logic             overflow_err;
    logic             underflow_err;
    logic             timeout_err;

    int total_checks = 0;
    int bad_checks   = 0;
    int tick_seen    = 0;
    int tick_base    = 0;
    int early        = 0;

    always #5 clk = ~clk;

    spike_packet_injector #(
        .PKT_W   (PKT_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .host_wen      (host_wen),
        .host_data     (host_data),
        .host_full     (host_full),
        .host_level    (host_level),
        .start         (start),
        .busy          (busy),
        .frame_done    (frame_done),
        .sent_count    (sent_count),
        .pkt_out       (pkt_out),
        .empty_out     (empty_out),
        .ren_in        (ren_in),
        .tick_out      (tick_out),
        .tick_ready_in (tick_ready_in),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err),
        .timeout_err   (timeout_err)
    );

    // Count tick pulses seen by the core.
    always @(posedge clk) begin
        if (tick_out) tick_seen <= tick_seen + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pkt(input logic [PKT_W-1:0] d);
        host_wen  = 1'b1;
        host_data = d;
        cyc();
        host_wen  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Core pops every cycle; expects n consecutive values from first, then the TICK cycle.
    task automatic drain_expect(input int n, input logic [PKT_W-1:0] first);
        for (int i = 0; i < n; i++) begin
            check_val("drain_empty", empty_out, 1'b0);
            check_val("drain_pkt", pkt_out, first + PKT_W'(i));
            ren_in = 1'b1;
            cyc();
        end
        ren_in = 1'b0;
        check_val("tick_after_drain", tick_out, 1'b1);
        check_val("sent_count", sent_count, n);
        check_val("empty_in_tick", empty_out, 1'b1);
    endtask

    // From the TICK cycle: acknowledge one cycle into WAIT.
    task automatic finish_wait();
        cyc();
        tick_ready_in = 1'b1;
        #1;
        check_val("ready_done", frame_done, 1'b1);
        cyc();
        tick_ready_in = 1'b0;
        check_val("ready_idle", busy, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_empty", empty_out, 1'b1);
        check_val("rst_pkt", pkt_out, 30'h0);
        check_val("rst_full", host_full, 1'b0);
        check_val("rst_level", host_level, 9'd0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", frame_done, 1'b0);
        check_val("rst_tick", tick_out, 1'b0);
        check_val("rst_sent", sent_count, 9'd0);
        check_val("rst_errs", {overflow_err, underflow_err, timeout_err}, 3'b000);
        reset = 1'b0;
        cyc();

        // Basic 3-packet frame, ready 5 cycles after tick, start ignored while busy.
        write_pkt(30'h1);
        write_pkt(30'h2);
        write_pkt(30'h3);
        check_val("t1_level", host_level, 9'd3);
        tick_base = tick_seen;
        pulse_start();
        drain_expect(3, 30'h1);
        for (int j = 1; j <= 4; j++) begin
            cyc();
            start = (j == 2);
            check_val("t1_wait_done", frame_done, 1'b0);
            check_val("t1_wait_busy", busy, 1'b1);
        end
        cyc();
        start = 1'b0;
        tick_ready_in = 1'b1;
        #1;
        check_val("t1_done", frame_done, 1'b1);
        cyc();
        tick_ready_in = 1'b0;
        check_val("t1_idle", busy, 1'b0);
        check_val("t1_done_clr", frame_done, 1'b0);
        check_val("t1_sent_kept", sent_count, 9'd3);
        check_val("t1_ticks", tick_seen - tick_base, 1);

        // Empty frame: tick and frame_done together, no wait.
        tick_base = tick_seen;
        pulse_start();
        check_val("t2_tick", tick_out, 1'b1);
        check_val("t2_done", frame_done, 1'b1);
        check_val("t2_sent", sent_count, 9'd0);
        cyc();
        check_val("t2_idle", busy, 1'b0);
        check_val("t2_done_clr", frame_done, 1'b0);
        check_val("t2_ticks", tick_seen - tick_base, 1);

        // Writes during DRAIN are left for the next frame.
        write_pkt(30'h11);
        write_pkt(30'h12);
        pulse_start();
        check_val("t3_pkt0", pkt_out, 30'h11);
        ren_in = 1'b1;
        host_wen = 1'b1;
        host_data = 30'h13;
        cyc();
        check_val("t3_level_wr_pop", host_level, 9'd2);
        check_val("t3_pkt1", pkt_out, 30'h12);
        host_data = 30'h14;
        cyc();
        ren_in = 1'b0;
        host_wen = 1'b0;
        check_val("t3_tick", tick_out, 1'b1);
        check_val("t3_sent", sent_count, 9'd2);
        check_val("t3_level", host_level, 9'd2);
        finish_wait();
        pulse_start();
        drain_expect(2, 30'h13);
        check_val("t3_level_end", host_level, 9'd0);
        finish_wait();

        // Fill to DEPTH, overflow write is dropped.
        for (int i = 0; i < DEPTH; i++) write_pkt(30'h100 + PKT_W'(i));
        check_val("t4_full", host_full, 1'b1);
        check_val("t4_level", host_level, 9'd256);
        check_val("t4_no_ovf", overflow_err, 1'b0);
        write_pkt(30'h3FFF_FFFF);
        check_val("t4_ovf", overflow_err, 1'b1);
        check_val("t4_level_ovf", host_level, 9'd256);
        pulse_start();
        drain_expect(DEPTH, 30'h100);
        check_val("t4_level_end", host_level, 9'd0);
        check_val("t4_full_end", host_full, 1'b0);
        finish_wait();

        // No tick_ready: frame_done exactly TIMEOUT cycles after tick_out.
        write_pkt(30'h2A);
        pulse_start();
        drain_expect(1, 30'h2A);
        early = 0;
        for (int j = 1; j < TIMEOUT; j++) begin
            cyc();
            if (frame_done) early++;
        end
        check_val("t5_early_done", early, 0);
        cyc();
        check_val("t5_done", frame_done, 1'b1);
        check_val("t5_err_pre", timeout_err, 1'b0);
        cyc();
        check_val("t5_idle", busy, 1'b0);
        check_val("t5_err", timeout_err, 1'b1);

        // Underflow in IDLE does not pop.
        write_pkt(30'h55);
        ren_in = 1'b1;
        cyc();
        ren_in = 1'b0;
        check_val("t6_udf", underflow_err, 1'b1);
        check_val("t6_level", host_level, 9'd1);

        // Reset in the middle of DRAIN.
        write_pkt(30'h56);
        pulse_start();
        check_val("t6_pkt0", pkt_out, 30'h55);
        ren_in = 1'b1;
        cyc();
        ren_in = 1'b0;
        check_val("t6_sent1", sent_count, 9'd1);
        check_val("t6_pkt1", pkt_out, 30'h56);
        check_val("t6_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check_val("t6_rst_busy", busy, 1'b0);
        check_val("t6_rst_empty", empty_out, 1'b1);
        check_val("t6_rst_level", host_level, 9'd0);
        check_val("t6_rst_sent", sent_count, 9'd0);
        check_val("t6_rst_errs", {overflow_err, underflow_err, timeout_err}, 3'b000);
        tick_base = tick_seen;
        cyc();
        reset = 1'b0;
        repeat (3) cyc();
        check_val("t6_no_tick", tick_seen - tick_base, 0);
        check_val("t6_no_done", frame_done, 1'b0);
        check_val("t6_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/spike_packet_injector.md
# spike_packet_injector

Host-side frame sequencer that sits directly upstream of a single-core SNN tile. It buffers 30-bit spike packets written by the host and presents them on the core's west input with the core's empty/ren handshake. Once the frame is drained, it issues one `tick_out` pulse and waits for the core's `tick_ready` before declaring the frame complete. It turns an asynchronous host write stream into tick-aligned frames and reports handshake and timing faults.

## Interface
- `PKT_W`, 30, packet width; matches core east/west inputs.
- `DEPTH`, 256, FIFO entries; must be a power of 2.
- `TIMEOUT`, 4096, max cycles to wait for `tick_ready_in` after a tick.
- `CNT_W`, `$clog2(DEPTH)+1`, width of counters.

Ports:
- `clk`  in  1  single clock; all logic is posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `host_wen`  in  1  write `host_data` into the FIFO.
- `host_data`  in  `PKT_W`  packet from the host.
- `host_full`  out  1  FIFO full.
- `host_level`  out  `CNT_W`  current FIFO occupancy.
- `start`  in  1  one-cycle pulse; begins a frame.
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse when a frame completes.
- `sent_count`  out  `CNT_W`  packets popped in the current or last frame.
- `pkt_out`  out  `PKT_W`  FIFO head, driven to core `west_in`.
- `empty_out`  out  1  driven to core `empty_in_west`; 0 means `pkt_out` is valid.
- `ren_in`  in  1  from core `ren_out_west`; pops the head.
- `tick_out`  out  1  one-cycle tick to the core.
- `tick_ready_in`  in  1  from core `tick_ready`.
- `overflow_err`  out  1  sticky; a write occurred while full.
- `underflow_err`  out  1  sticky; `ren_in` arrived while `empty_out`=1.
- `timeout_err`  out  1  sticky; `TIMEOUT` expired in WAIT.

## Operation
FSM states:
- **IDLE**: `empty_out`=1. On `start`, latch `frame_len` = `host_level`, clear `sent_count`, go to DRAIN. If `frame_len`=0, go to TICK instead.
- **DRAIN**: `empty_out` = (`remaining`==0). Each `ren_in` with `empty_out`=0 pops one entry, increments `sent_count` and decrements `remaining`. When the last pop occurs (`remaining`==1 and `ren_in`), go to TICK.
- **TICK**: `tick_out`=1 for exactly one cycle.
  - If `frame_len`=0, go to IDLE and pulse `frame_done` on that cycle.
  - Otherwise go to WAIT and clear the timeout counter.
- **WAIT**: on `tick_ready_in`=1, pulse `frame_done` and go to IDLE. If the counter reaches `TIMEOUT`-1, set `timeout_err`, pulse `frame_done` and go to IDLE.

Rules and boundary conditions:
- Host writes are accepted in every state; a write and a pop in the same cycle leaves `host_level` unchanged.
- Entries written after `start` are excluded from the current frame, which drains exactly `frame_len` entries.
- A write while full is dropped, sets `overflow_err`, and leaves FIFO contents unchanged.
- `ren_in` while `empty_out`=1 is ignored (no pop) and sets `underflow_err`.
- `start` is ignored while `busy`.
- `tick_ready_in` outside WAIT is ignored.
- Counters saturate at no point: `DEPTH` bounds them and `CNT_W` holds `DEPTH`.
- Sticky errors clear only on `reset`.

## Timing
- The FIFO is first-word-fall-through. `pkt_out` is valid in the same cycle `empty_out` falls. After a pop at edge N, the next entry is on `pkt_out` after edge N.
- `empty_out` falls in the cycle after `start` is sampled; drain can therefore begin 1 cycle after `start`.
- `tick_out` asserts the cycle after the final pop edge.
- Worst-case frame latency is `frame_len` + 2 + `TIMEOUT` cycles.
- Reset values:
  - FSM = IDLE; FIFO empty.
  - `empty_out`=1; `pkt_out`=0.
  - `host_full`, `host_level`, `busy`, `frame_done`, `tick_out`, `sent_count` and all error flags = 0.
- Reset asserted mid-frame returns the block to IDLE and empties the FIFO. No `tick_out` or `frame_done` is emitted.

## Structure
- Package `snn_inject_pkg` holds:
  - `state_t` enum {IDLE, DRAIN, TICK, WAIT};
  - `PKT_W`;
  - packet field constants `DX_MSB`=29, `DY_MSB`=20, `AXON_MSB`=11, `DT_MSB`=3, kept for debug decode only, since the block treats packets as opaque.
- One sub-module, `sync_fifo_fwft` (`DEPTH`, `PKT_W`), provides full, empty and level outputs.
- FSM, counters and error flags live in the top level.

## Test plan
- Write 3 packets 0x1, 0x2, 0x3, then pulse `start`; core model pops every cycle.
  - `pkt_out` sequence 1, 2, 3; `sent_count`=3.
  - `tick_out` pulses once; `tick_ready_in` 5 cycles later gives `frame_done` and `busy`=0.
- Pulse `start` with the FIFO empty: `tick_out` on cycle 2, `frame_done` in the same cycle, no wait.
- Write 2 packets, pulse `start`, write 2 more during DRAIN.
  - Only 2 are popped; `host_level`=2 afterwards.
  - A second `start` drains the remaining 2.
- Fill to `DEPTH`, then write once more: `overflow_err`=1, `host_level`=`DEPTH`, and draining returns the original data.
- Never assert `tick_ready_in`: `timeout_err`=1 and `frame_done` exactly `TIMEOUT` cycles after `tick_out`.
- Assert `ren_in` in IDLE: `underflow_err`=1 and no pop occurs. Apply `reset` mid-DRAIN: IDLE, `empty_out`=1, all counters 0.
